// File: rtl/btn_debounce.sv
// Pushbutton conditioner: two-flop synchroniser, debounce FSM, registered level/edge pulses.
// Optional auto-repeat of step_o while held is enabled by defining BTN_DEBOUNCE_AUTOREPEAT_EN.
module btn_debounce #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 16,
  parameter int REPEAT_DELAY  = 64,
  parameter int REPEAT_PERIOD = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic step_o
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  if (STABLE_CYCLES < 2 || longint'(STABLE_CYCLES) > ((longint'(1) << CNT_W) - 1) ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("btn_debounce: illegal parameter combination");
  end

  state_t           state, state_next;
  logic             s1, s2;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
  logic             level_next, rise_next, fall_next, step_next;

  // Only s2 is allowed to reach the FSM; s1 may go metastable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_i;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    level_next = level_o;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (s2) begin
          state_next = PRESS_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = HELD;
          cnt_next   = '0;
          level_next = 1'b1;
          rise_next  = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      HELD: begin
        if (!s2) begin
          state_next = RELEASE_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s2) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
          level_next = 1'b0;
          fall_next  = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [CNT_W-1:0] rcnt, rcnt_next;
  logic             repeat_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rcnt <= '0;
    end else begin
      rcnt <= rcnt_next;
    end
  end

  // rcnt runs only in HELD and is frozen across a release bounce so a bounce does not restart the delay.
  always_comb begin
    rcnt_next  = rcnt;
    repeat_hit = 1'b0;
    unique case (state)
      HELD: begin
        if (rcnt == RPT_LAST) begin
          repeat_hit = 1'b1;
          rcnt_next  = RPT_RELOAD;
        end else if (rcnt != CNT_MAX) begin
          rcnt_next = rcnt + CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (state_next == IDLE) begin
          rcnt_next = '0;
        end
      end
      default: rcnt_next = '0;
    endcase
  end

  assign step_next = rise_next | repeat_hit;
`else
  assign step_next = rise_next;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_o <= 1'b0;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
      step_o  <= 1'b0;
    end else begin
      level_o <= level_next;
      rise_o  <= rise_next;
      fall_o  <= fall_next;
      step_o  <= step_next;
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Testbench for btn_debounce: directed and random button patterns checked every cycle
// against a run-length reference model of the debounced button.
module tb_btn_debounce;

  localparam int STABLE = 4;
  localparam int DELAY  = 8;
  localparam int PERIOD = 4;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_ni;
  logic btn_i;
  logic level_o, rise_o, fall_o, step_o;

  int total = 0;
  int bad   = 0;

  // Reference model state: raw samples delayed two edges, run length of samples disagreeing
  // with the accepted level, and number of edges spent settled in the pressed level.
  bit m_d1, m_d2, m_lvl, m_rise, m_fall, m_step;
  int m_run, m_age;

  int rise_seen, fall_seen, step_seen;
  int lat, burst_len;
  logic burst_val;

  btn_debounce #(
    .STABLE_CYCLES(STABLE),
    .CNT_W(16),
    .REPEAT_DELAY(DELAY),
    .REPEAT_PERIOD(PERIOD)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .btn_i(btn_i),
    .level_o(level_o),
    .rise_o(rise_o),
    .fall_o(fall_o),
    .step_o(step_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void model_reset();
    m_d1 = 0; m_d2 = 0; m_lvl = 0; m_rise = 0; m_fall = 0; m_step = 0;
    m_run = 0; m_age = 0;
  endfunction

  function automatic void model_edge(input bit b);
    bit seen, settled;
    seen    = m_d2;
    m_d2    = m_d1;
    m_d1    = b;
    settled = m_lvl && (m_run == 0);
    m_rise  = 0;
    m_fall  = 0;
    m_step  = 0;
    if (seen != m_lvl) begin
      m_run++;
      if (m_run == STABLE) begin
        m_lvl = seen;
        m_run = 0;
        if (seen) begin
          m_rise = 1;
          m_age  = 0;
        end else begin
          m_fall = 1;
        end
      end
    end else begin
      m_run = 0;
    end
    if (AUTO && settled) begin
      m_age++;
      if (m_age >= DELAY && ((m_age - DELAY) % PERIOD) == 0) m_step = 1;
    end
    if (m_rise) m_step = 1;
  endfunction

  task automatic check_bit(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_output();
    check_bit("level_o", level_o, m_lvl);
    check_bit("rise_o", rise_o, m_rise);
    check_bit("fall_o", fall_o, m_fall);
    check_bit("step_o", step_o, m_step);
    check_bit("rise_fall_excl", rise_o & fall_o, 1'b0);
  endtask

  // One clock of stimulus: drive btn_i, advance the model on the edge, check 1ns later.
  task automatic apply_stimulus(input logic b);
    btn_i = b;
    @(posedge clk_i);
    if (rst_ni) model_edge(b);
    #1;
    if (rise_o === 1'b1) rise_seen++;
    if (fall_o === 1'b1) fall_seen++;
    if (step_o === 1'b1) step_seen++;
    check_output();
  endtask

  task automatic clear_seen();
    rise_seen = 0; fall_seen = 0; step_seen = 0;
  endtask

  task automatic run_until_rise(input logic b, output int cycles);
    cycles = -1;
    for (int i = 1; i <= 20; i++) begin
      apply_stimulus(b);
      if (rise_o === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic run_until_fall(input logic b, output int cycles);
    cycles = -1;
    for (int i = 1; i <= 20; i++) begin
      apply_stimulus(b);
      if (fall_o === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    logic [4:0] bounce;

    // Reset with the button held, then release reset while still held.
    rst_ni = 1'b0;
    btn_i  = 1'b1;
    model_reset();
    #1;
    check_output();
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1);
    rst_ni = 1'b1;
    clear_seen();
    run_until_rise(1'b1, lat);
    check_int("reset_release_rise_latency", lat, STABLE + 2);
    for (int i = 0; i < 12; i++) apply_stimulus(1'b0);
    check_int("reset_release_fall_count", fall_seen, 1);

    // Short bounce never reaches the stable count.
    bounce = 5'b01101;
    clear_seen();
    for (int i = 0; i < 5; i++) apply_stimulus(bounce[i]);
    for (int i = 0; i < 12; i++) apply_stimulus(1'b0);
    check_int("bounce_rise_count", rise_seen, 0);
    check_int("bounce_step_count", step_seen, 0);
    check_bit("bounce_level", level_o, 1'b0);

    // Clean press held for 20 cycles.
    clear_seen();
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      apply_stimulus(1'b1);
      if (rise_o === 1'b1) lat = i;
    end
    check_int("press_rise_latency", lat, STABLE + 2);
    check_int("press_rise_count", rise_seen, 1);
    check_int("press_step_count", step_seen, AUTO ? 3 : 1);
    check_bit("press_level", level_o, 1'b1);

    // Release with a bounce: 0,0,1 then steady 0.
    clear_seen();
    apply_stimulus(1'b0);
    apply_stimulus(1'b0);
    apply_stimulus(1'b1);
    run_until_fall(1'b0, lat);
    check_int("release_fall_latency", lat, STABLE + 2);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0);
    check_int("release_fall_count", fall_seen, 1);
    check_int("release_rise_count", rise_seen, 0);

    // Reset asserted mid-press, two samples into the stability count.
    clear_seen();
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1);
    rst_ni = 1'b0;
    #1;
    model_reset();
    check_output();
    apply_stimulus(1'b1);
    apply_stimulus(1'b1);
    rst_ni = 1'b1;
    run_until_rise(1'b1, lat);
    check_int("midreset_rise_latency", lat, STABLE + 2);
    check_int("midreset_rise_count", rise_seen, 1);

    // Hold 30 cycles after the rise: auto-repeat steps at +8, +12, ... when enabled.
    step_seen = 1;
    for (int i = 0; i < 30; i++) apply_stimulus(1'b1);
    check_int("hold_step_count", step_seen, AUTO ? 7 : 1);
    clear_seen();
    for (int i = 0; i < 12; i++) apply_stimulus(1'b0);
    check_int("hold_fall_count", fall_seen, 1);

    // Random bursts of varying length exercise glitches, bounces and long holds.
    for (int n = 0; n < 60; n++) begin
      burst_val = 1'($urandom_range(0, 1));
      burst_len = $urandom_range(1, (n % 4 == 0) ? 24 : 7);
      for (int i = 0; i < burst_len; i++) apply_stimulus(burst_val);
    end
    for (int i = 0; i < 12; i++) apply_stimulus(1'b0);
    check_bit("final_level", level_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
